// File: rtl/cam_pkg.sv
// Shared definitions for the camera power-up sequencer: state encodings,
// default phase lengths for a 50 MHz clock, and per-state pin decoding.
package cam_pkg;

  localparam int CNT_W_DEF = 20;

  localparam logic [19:0] T_PWR_DEF    = 20'd100000;
  localparam logic [19:0] T_RST_DEF    = 20'd50000;
  localparam logic [19:0] T_INIT_DEF   = 20'd200000;
  localparam logic [19:0] T_CFG_TO_DEF = 20'd1000000;
  localparam logic [19:0] T_SETTLE_DEF = 20'd100000;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PWR      = 3'd1;
  localparam logic [2:0] ST_PWDN_REL = 3'd2;
  localparam logic [2:0] ST_RST_REL  = 3'd3;
  localparam logic [2:0] ST_CFG      = 3'd4;
  localparam logic [2:0] ST_SETTLE   = 3'd5;
  localparam logic [2:0] ST_READY    = 3'd6;
  localparam logic [2:0] ST_ERR      = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_PWR      = ST_PWR,
    S_PWDN_REL = ST_PWDN_REL,
    S_RST_REL  = ST_RST_REL,
    S_CFG      = ST_CFG,
    S_SETTLE   = ST_SETTLE,
    S_READY    = ST_READY,
    S_ERR      = ST_ERR
  } state_e;

  typedef struct packed {
    logic pwdn;
    logic rst_n;
  } pins_t;

  function automatic pins_t pins_for(state_e s);
    pins_t p;
    case (s)
      S_PWDN_REL:                           p = '{pwdn: 1'b0, rst_n: 1'b0};
      S_RST_REL, S_CFG, S_SETTLE, S_READY:  p = '{pwdn: 1'b0, rst_n: 1'b1};
      default:                              p = '{pwdn: 1'b1, rst_n: 1'b0};
    endcase
    return p;
  endfunction

  // Timed states: the shared phase timer only counts here.
  function automatic logic is_busy(state_e s);
    return (s == S_PWR) || (s == S_PWDN_REL) || (s == S_RST_REL) ||
           (s == S_CFG) || (s == S_SETTLE);
  endfunction

endpackage

// File: rtl/cam_pwr_seq_phase_timer.sv
// Saturating phase timer; clear wins over enable so each phase starts at 0.
module phase_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cam_pwr_seq.sv
// Camera power-up sequencer: walks the sensor pins through timed phases,
// launches configuration, and reports ready or a configuration timeout.
module cam_pwr_seq
  import cam_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] T_PWR    = CNT_W'(T_PWR_DEF),
  parameter logic [CNT_W-1:0] T_RST    = CNT_W'(T_RST_DEF),
  parameter logic [CNT_W-1:0] T_INIT   = CNT_W'(T_INIT_DEF),
  parameter logic [CNT_W-1:0] T_CFG_TO = CNT_W'(T_CFG_TO_DEF),
  parameter logic [CNT_W-1:0] T_SETTLE = CNT_W'(T_SETTLE_DEF)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cfg_done,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       cfg_start,
  output logic       busy,
  output logic       ready,
  output logic       err,
  output logic [2:0] state
);

  state_e           state_q, state_d;
  logic             state_chg;
  logic [CNT_W-1:0] timer;
  logic             pwdn_q, rst_n_q, cfg_start_q, busy_q, ready_q, err_q;
  pins_t            pins_d;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_chg),
    .en    (is_busy(state_q)),
    .count (timer)
  );

  // NOTE: state_d takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_PWR;
      S_PWR:      if (timer == T_PWR - CNT_W'(1)) state_d = S_PWDN_REL;
      S_PWDN_REL: if (timer == T_RST - CNT_W'(1)) state_d = S_RST_REL;
      S_RST_REL:  if (timer == T_INIT - CNT_W'(1)) state_d = S_CFG;
      S_CFG: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (cfg_done)                            state_d = S_SETTLE;
        else if (timer == T_CFG_TO - CNT_W'(1)) state_d = S_ERR;
      end
      S_SETTLE:   if (timer == T_SETTLE - CNT_W'(1)) state_d = S_READY;
      S_READY,
      S_ERR:      if (start) state_d = S_PWR;
      default:    state_d = S_IDLE;
    endcase
  end

  assign state_chg = (state_d != state_q);
  assign pins_d    = pins_for(state_d);

  // Outputs are decoded from the next state so they change with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pwdn_q      <= 1'b1;
      rst_n_q     <= 1'b0;
      cfg_start_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwdn_q      <= pins_d.pwdn;
      rst_n_q     <= pins_d.rst_n;
      cfg_start_q <= (state_d == S_CFG) && (state_q != S_CFG);
      busy_q      <= is_busy(state_d);
      ready_q     <= (state_d == S_READY);
      err_q       <= (state_d == S_ERR);
    end
  end

  assign cam_pwdn  = pwdn_q;
  assign cam_rst_n = rst_n_q;
  assign cfg_start = cfg_start_q;
  assign busy      = busy_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Scoreboard bench for cam_pwr_seq: a phase-level reference model queues the
// expected outputs every cycle and a monitor compares them on the falling edge.
module tb_cam_pwr_seq;

  localparam int M_T_PWR    = 4;
  localparam int M_T_RST    = 3;
  localparam int M_T_INIT   = 5;
  localparam int M_T_CFG_TO = 10;
  localparam int M_T_SETTLE = 2;

  localparam int P_IDLE = 0, P_PWR = 1, P_PWDN_REL = 2, P_RST_REL = 3;
  localparam int P_CFG = 4, P_SETTLE = 5, P_READY = 6, P_ERR = 7;

  typedef struct packed {
    logic [2:0] st;
    logic       pwdn;
    logic       rst_n;
    logic       cfg_start;
    logic       busy;
    logic       ready;
    logic       err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cam_pwdn, cam_rst_n, cfg_start, busy, ready, err;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  obs_t sb_q[$];

  // Reference model: current phase and cycles already spent in it.
  int   m_state = P_IDLE;
  int   m_cycle = 0;
  logic m_err   = 1'b0;

  cam_pwr_seq #(
    .CNT_W   (20),
    .T_PWR   (20'(M_T_PWR)),
    .T_RST   (20'(M_T_RST)),
    .T_INIT  (20'(M_T_INIT)),
    .T_CFG_TO(20'(M_T_CFG_TO)),
    .T_SETTLE(20'(M_T_SETTLE))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_done (cfg_done),
    .cam_pwdn (cam_pwdn),
    .cam_rst_n(cam_rst_n),
    .cfg_start(cfg_start),
    .busy     (busy),
    .ready    (ready),
    .err      (err),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int phase_len(input int s);
    case (s)
      P_PWR:      return M_T_PWR;
      P_PWDN_REL: return M_T_RST;
      P_RST_REL:  return M_T_INIT;
      P_CFG:      return M_T_CFG_TO;
      P_SETTLE:   return M_T_SETTLE;
      default:    return 0;
    endcase
  endfunction

  // Model: advance one clock and queue what the DUT should show after it.
  initial begin
    forever begin
      int   nxt;
      logic pulse;
      obs_t e;
      @(posedge clk);
      pulse = 1'b0;
      if (rst) begin
        m_state = P_IDLE;
        m_cycle = 0;
        m_err   = 1'b0;
      end else begin
        nxt = m_state;
        if (m_state == P_IDLE || m_state == P_READY || m_state == P_ERR) begin
          if (start) nxt = P_PWR;
        end else if (m_state == P_CFG && cfg_done) begin
          nxt = P_SETTLE;
        end else if (m_cycle + 1 >= phase_len(m_state)) begin
          nxt = (m_state == P_CFG) ? P_ERR : m_state + 1;
        end
        if (nxt == P_ERR) m_err = 1'b1;
        if (nxt == P_PWR) m_err = 1'b0;
        pulse   = (nxt == P_CFG) && (m_state != P_CFG);
        m_cycle = (nxt != m_state) ? 0 : m_cycle + 1;
        m_state = nxt;
      end
      e.st        = 3'(m_state);
      e.pwdn      = (m_state == P_IDLE) || (m_state == P_PWR) || (m_state == P_ERR);
      e.rst_n     = (m_state >= P_RST_REL) && (m_state <= P_READY);
      e.cfg_start = pulse;
      e.busy      = (m_state >= P_PWR) && (m_state <= P_SETTLE);
      e.ready     = (m_state == P_READY);
      e.err       = m_err;
      sb_q.push_back(e);
    end
  end

  // Monitor: compare each registered output word away from the active edge.
  initial begin
    forever begin
      obs_t a, e;
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        a = '{state, cam_pwdn, cam_rst_n, cfg_start, busy, ready, err};
        check("outputs{st,pwdn,rst_n,cfg_start,busy,ready,err}", 16'(a), 16'(e));
      end
    end
  end

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (m_state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach_state_%0d", s), 16'(m_state == s), 16'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_done();
    cfg_done = 1'b1;
    @(negedge clk);
    cfg_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Nominal run, completion on the third CFG cycle.
    pulse_start();
    wait_state(P_CFG, 40);
    repeat (2) @(negedge clk);
    pulse_done();
    wait_state(P_READY, 20);
    repeat (3) @(negedge clk);

    // Re-run from READY with ignored inputs, then no completion: timeout.
    pulse_start();
    wait_state(P_PWDN_REL, 20);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_state(P_RST_REL, 20);
    @(negedge clk);
    pulse_done();
    wait_state(P_ERR, 40);
    repeat (3) @(negedge clk);

    // Restart from ERR; completion races the timeout on the 10th CFG cycle.
    pulse_start();
    wait_state(P_CFG, 40);
    repeat (9) @(negedge clk);
    pulse_done();
    wait_state(P_READY, 20);
    repeat (2) @(negedge clk);

    // Reset during RST_REL, then a fresh run with completion alongside cfg_start.
    pulse_start();
    wait_state(P_RST_REL, 40);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start();
    wait_state(P_CFG, 40);
    pulse_done();
    wait_state(P_READY, 20);
    repeat (2) @(negedge clk);

    // Randomised traffic, including held start and occasional resets.
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom_range(0, 15) == 0);
      cfg_done = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 249) == 0);
      @(negedge clk);
    end
    start    = 1'b0;
    cfg_done = 1'b0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cam_pwr_seq.md
Name: cam_pwr_seq

Overview:
- Camera power-up and initialisation sequencer for the image front end.
- Drives the sensor power-down and reset pins through timed phases, launches the register-configuration engine, waits for it to finish, then asserts `ready` to the capture pipeline.
- Phase timing comes from one shared saturating phase timer that the FSM re-arms on every state change.

Parameters:
- CNT_W, 20, width of phase timer; must hold the largest T_* value.
- T_PWR, 20'd100000, cycles with pwdn=1 and rst_n=0 after start.
- T_RST, 20'd50000, cycles with pwdn=0 and rst_n=0.
- T_INIT, 20'd200000, cycles after rst_n release before configuration.
- T_CFG_TO, 20'd1000000, timeout cycles waiting for cfg_done.
- T_SETTLE, 20'd100000, cycles after cfg_done before ready.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- start  in  1  level/pulse request to run or re-run the sequence.
- cfg_done  in  1  one-cycle pulse from the configuration engine.
- cam_pwdn  out  1  sensor power-down, active-high.
- cam_rst_n  out  1  sensor reset, active-low.
- cfg_start  out  1  one-cycle pulse to the configuration engine.
- busy  out  1  sequence in progress.
- ready  out  1  sensor configured and settled.
- err  out  1  configuration timed out; sticky until next start or rst.
- state  out  3  current FSM state, for debug.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, cam_pwdn=1, cam_rst_n=0, cfg_start=0, busy=0, ready=0, err=0, timer=0.
- Reset asserted mid-sequence forces these values at the next edge, with no completion of the current phase.
- States and encodings: IDLE=0, PWR=1, PWDN_REL=2, RST_REL=3, CFG=4, SETTLE=5, READY=6, ERR=7.
- Pin values per state:
  - IDLE, PWR, ERR: pwdn=1, rst_n=0.
  - PWDN_REL: pwdn=0, rst_n=0.
  - RST_REL, CFG, SETTLE, READY: pwdn=0, rst_n=1.
- busy=1 in states 1-5. ready=1 only in READY.
- Phase timer:
  - Counts up from 0 while the FSM is in a timed state, saturating at its maximum.
  - Forced to 0 in the cycle the state changes, so every phase starts at 0.
  - A phase of length T ends when timer==T-1, giving exactly T cycles in the state.
  - Every T_* must be ≥1.
- Transitions:
  - IDLE: start=1 → PWR.
  - PWR: timer==T_PWR-1 → PWDN_REL.
  - PWDN_REL: timer==T_RST-1 → RST_REL.
  - RST_REL: timer==T_INIT-1 → CFG. cfg_start=1 for exactly the first cycle in CFG.
  - CFG: cfg_done=1 → SETTLE; otherwise timer==T_CFG_TO-1 → ERR and err:=1.
  - SETTLE: timer==T_SETTLE-1 → READY.
  - READY, ERR: start=1 → PWR, clearing err and ready.
- Simultaneous events and ignored inputs:
  - cfg_done and timeout in the same cycle: cfg_done wins (SETTLE, no err).
  - cfg_done outside CFG is ignored.
  - start while busy is ignored.
  - cfg_done in the same cycle as the cfg_start pulse is accepted.
- Latency: start sampled at edge k makes busy=1 and state=PWR visible after edge k.
- A held start level in READY re-runs the sequence continuously. The requester must drop start once ready is seen.

Decomposition:
- Shared package cam_pkg holds the state encodings (3-bit localparams) and the default T_* constants for 50 MHz.
- One sub-module, phase_timer:
  - CNT_W saturating up-counter with synchronous active-high clear and count enable.
  - Clear has priority over enable.
- The FSM asserts clear on every state change and enable in states 1-5.

Test Plan:
- Test parameters: T_PWR=4, T_RST=3, T_INIT=5, T_CFG_TO=10, T_SETTLE=2.
- Nominal run:
  - Stimulus: start pulse at cycle 0; cfg_done at the 3rd CFG cycle.
  - Response: PWR for 4 cycles, PWDN_REL 3, RST_REL 5.
  - cam_pwdn falls on PWR→PWDN_REL; cam_rst_n rises 3 cycles later.
  - cfg_start is high for exactly 1 cycle; SETTLE lasts 2 cycles; ready=1, busy=0.
- Timeout:
  - Stimulus: no cfg_done.
  - Response: CFG lasts exactly 10 cycles, then ERR with err=1, pwdn=1, rst_n=0.
  - A later start clears err and PWR re-enters.
- Race:
  - Stimulus: cfg_done on the 10th CFG cycle.
  - Response: SETTLE, err stays 0.
- Reset mid-sequence:
  - Stimulus: rst during RST_REL.
  - Response: next cycle IDLE, pwdn=1, rst_n=0, busy=0.
  - A subsequent start gives a full PWR phase of 4 cycles, with the timer restarted from 0.
- Ignored inputs:
  - Stimulus: start pulses during PWDN_REL; stray cfg_done in RST_REL.
  - Response: phase timing unchanged, no early transition.
- Re-init from READY:
  - Stimulus: start in READY.
  - Response: ready=0 and pwdn=1 next cycle; full sequence repeats.
